aw_write_arbiter_2m: RTL and testbench
======================================

// Module: aw_write_arbiter_2m
// PURPOSE
//  Two-master write-transaction arbiter; sits directly upstream of the 2:1 AW mux and drives its select.
//  Picks S00 or S01, holds the grant through AW handshake, W burst and B response, then releases.
//  Gates AWVALID/AWREADY per master and tracks W beats against AWLEN to flag length errors.
// PARAMETERS
//  S_Aw_len  8  width of awlen (AXI4 burst length field)
//  ARB_MODE  0  0 = round-robin between S00/S01; 1 = fixed priority, S00 always wins
// PORTS
//  ACLK             in   1         clock, all logic on rising edge
//  ARESETN          in   1         asynchronous active-low reset
//  S00_AXI_awvalid  in   1         master 0 write-address valid
//  S00_AXI_awlen    in   S_Aw_len  master 0 burst length (beats-1)
//  S00_AXI_awready  out  1         master 0 write-address ready
//  S01_AXI_awvalid  in   1         master 1 write-address valid
//  S01_AXI_awlen    in   S_Aw_len  master 1 burst length (beats-1)
//  S01_AXI_awready  out  1         master 1 write-address ready
//  Selected_Slave   out  1         AW mux select: 0 = S00, 1 = S01 (registered)
//  M_AXI_awvalid    out  1         gated AWVALID toward slave
//  M_AXI_awready    in   1         slave AWREADY
//  M_AXI_wvalid     in   1         W channel valid (slave side)
//  M_AXI_wready     in   1         W channel ready (slave side)
//  M_AXI_wlast      in   1         W channel last (slave side)
//  M_AXI_bvalid     in   1         B channel valid (slave side)
//  M_AXI_bready     in   1         B channel ready (slave side)
//  Write_Data_Sel   out  1         W/B mux select; equals Selected_Slave
//  Arb_Busy         out  1         1 whenever state != IDLE
//  W_Len_Err        out  1         one-cycle pulse: wlast position disagrees with awlen
// BEHAVIOUR
//  Reset (ARESETN=0, async): state=IDLE; Selected_Slave=0, Write_Data_Sel=0, M_AXI_awvalid=0,
//   S00/S01 awready=0, Arb_Busy=0, W_Len_Err=0, beat counter=0, last_grant=1 (S00 wins first).
//  Reset mid-transaction abandons it; no completion is emulated.
//  FSM states: IDLE -> AW -> W -> B -> IDLE.
//  IDLE: if any awvalid, register winner into Selected_Slave and go AW. Outputs stay 0 in IDLE.
//   Only S00 valid -> 0; only S01 valid -> 1; both valid: ARB_MODE=0 -> ~last_grant, ARB_MODE=1 -> 0.
//  Latency: request sampled at edge N -> Selected_Slave stable and M_AXI_awvalid driven from N+1.
//  AW: M_AXI_awvalid = awvalid of selected master; selected awready = M_AXI_awready; other awready=0.
//   On M_AXI_awvalid & M_AXI_awready: load beat counter with selected awlen, go W.
//   Selected master dropping awvalid before handshake: stay in AW, no re-arbitration.
//  W: each M_AXI_wvalid & M_AXI_wready beat: counter decrements, saturating at 0.
//   Beat with wlast=1 and counter!=0, or beat with wlast=0 and counter==0: W_Len_Err=1 next cycle, 1 cycle wide.
//   Go B only on a beat with wlast=1 (early or late wlast still terminates or extends the burst).
//   awlen=0: first beat is expected last.
//  B: on M_AXI_bvalid & M_AXI_bready: last_grant <= Selected_Slave, go IDLE.
//  Grant never changes outside IDLE; new requests arriving mid-transaction wait (awready held 0).
//  Back-to-back: B->IDLE->AW costs one IDLE cycle; no AW issued in the B-completion cycle.
//  Selected_Slave and Write_Data_Sel hold value through IDLE (not cleared on release).
//  Counter width = S_Aw_len; no arithmetic wrap (saturating).
// TESTING
//  Reset release, S00 valid, awlen=3, awready=1: awvalid at cycle+1, 4 W beats, wlast on 4th, B -> no error, back to IDLE.
//  Both valid every cycle, ARB_MODE=0, 4 transactions: grant order S00,S01,S00,S01.
//  Both valid, ARB_MODE=1, 3 transactions: all granted to S00; S01 awready never 1.
//  awlen=2, wlast on 2nd beat -> W_Len_Err pulse one cycle, state reaches B; awlen=0, wlast on 2nd beat -> error on 1st beat.
//  S01 requests while S00 in W state: S01_AXI_awready stays 0 until S00 B handshake; S01 granted next.
//  ARESETN pulled low in W state mid-burst -> all outputs 0 asynchronously, state IDLE, next grant S00.

Source files
------------

// File: rtl/aw_write_arbiter_2m.sv
// Two-master AXI write arbiter. Grants one of S00/S01, holds the grant through
// the AW handshake, the W burst and the B response, then releases it.
// W beats are counted against the granted AWLEN to flag wlast misplacement.
module aw_write_arbiter_2m #(
    parameter int          S_Aw_len = 8,
    parameter int unsigned ARB_MODE = 0
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                S00_AXI_awvalid,
    input  logic [S_Aw_len-1:0] S00_AXI_awlen,
    output logic                S00_AXI_awready,
    input  logic                S01_AXI_awvalid,
    input  logic [S_Aw_len-1:0] S01_AXI_awlen,
    output logic                S01_AXI_awready,
    output logic                Selected_Slave,
    output logic                M_AXI_awvalid,
    input  logic                M_AXI_awready,
    input  logic                M_AXI_wvalid,
    input  logic                M_AXI_wready,
    input  logic                M_AXI_wlast,
    input  logic                M_AXI_bvalid,
    input  logic                M_AXI_bready,
    output logic                Write_Data_Sel,
    output logic                Arb_Busy,
    output logic                W_Len_Err
);

    // state | meaning
    // IDLE  | no grant held; arbitrates any pending awvalid
    // AW    | grant held, waiting for the AW handshake of the selected master
    // W     | counting W beats until a beat with wlast
    // B     | waiting for the write response handshake
    typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

    localparam logic [S_Aw_len-1:0] CNT_ONE = {{(S_Aw_len-1){1'b0}}, 1'b1};

    state_t                state_q;
    logic                  sel_q;
    logic                  last_grant_q;
    logic                  len_err_q;
    logic [S_Aw_len-1:0]   cnt_q;

    logic                  winner;
    logic                  sel_awvalid;
    logic [S_Aw_len-1:0]   sel_awlen;
    logic                  aw_hs;
    logic                  w_beat;
    logic                  b_hs;
    logic                  beat_err;

    // Arbitration decision for the IDLE state; the tie-break depends on mode.
    always_comb begin
        winner = 1'b0;
        if (S00_AXI_awvalid && S01_AXI_awvalid) begin
            winner = (ARB_MODE == 1) ? 1'b0 : ~last_grant_q;
        end else if (S01_AXI_awvalid) begin
            winner = 1'b1;
        end
    end

    // Channel routing for the currently granted master and handshake decode.
    always_comb begin
        sel_awvalid     = sel_q ? S01_AXI_awvalid : S00_AXI_awvalid;
        sel_awlen       = sel_q ? S01_AXI_awlen   : S00_AXI_awlen;
        M_AXI_awvalid   = (state_q == AW) && sel_awvalid;
        S00_AXI_awready = (state_q == AW) && !sel_q && M_AXI_awready;
        S01_AXI_awready = (state_q == AW) &&  sel_q && M_AXI_awready;
        aw_hs           = M_AXI_awvalid && M_AXI_awready;
        w_beat          = M_AXI_wvalid && M_AXI_wready;
        b_hs            = M_AXI_bvalid && M_AXI_bready;
        beat_err        = (M_AXI_wlast && (cnt_q != '0)) || (!M_AXI_wlast && (cnt_q == '0));
    end

    // Transaction FSM with grant, beat counter and error pulse registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= IDLE;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
            len_err_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            len_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (S00_AXI_awvalid || S01_AXI_awvalid) begin
                        sel_q   <= winner;
                        state_q <= AW;
                    end
                end
                AW: begin
                    if (aw_hs) begin
                        cnt_q   <= sel_awlen;
                        state_q <= W;
                    end
                end
                W: begin
                    if (w_beat) begin
                        len_err_q <= beat_err;
                        // Saturate so a late wlast cannot wrap the counter.
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                        if (M_AXI_wlast) begin
                            state_q <= B;
                        end
                    end
                end
                B: begin
                    if (b_hs) begin
                        last_grant_q <= sel_q;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Status outputs taken straight from registers.
    always_comb begin
        Selected_Slave = sel_q;
        Write_Data_Sel = sel_q;
        Arb_Busy       = (state_q != IDLE);
        W_Len_Err      = len_err_q;
    end

endmodule

// File: tb/tb_aw_write_arbiter_2m.sv
// Directed bench: one round-robin instance and one fixed-priority instance
// share all inputs; each scenario task checks its own expectations inline.
module tb_aw_write_arbiter_2m;

    logic       ACLK = 1'b0;
    logic       ARESETN;
    logic       s00_valid, s01_valid;
    logic [7:0] s00_len, s01_len;
    logic       m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;

    logic s00_rdy0, s01_rdy0, sel0, awv0, wds0, busy0, err0;
    logic s00_rdy1, s01_rdy1, sel1, awv1, wds1, busy1, err1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 ACLK = ~ACLK;

    aw_write_arbiter_2m #(.S_Aw_len(8), .ARB_MODE(0)) dut_rr (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S00_AXI_awvalid(s00_valid), .S00_AXI_awlen(s00_len), .S00_AXI_awready(s00_rdy0),
        .S01_AXI_awvalid(s01_valid), .S01_AXI_awlen(s01_len), .S01_AXI_awready(s01_rdy0),
        .Selected_Slave(sel0), .M_AXI_awvalid(awv0), .M_AXI_awready(m_awready),
        .M_AXI_wvalid(m_wvalid), .M_AXI_wready(m_wready), .M_AXI_wlast(m_wlast),
        .M_AXI_bvalid(m_bvalid), .M_AXI_bready(m_bready),
        .Write_Data_Sel(wds0), .Arb_Busy(busy0), .W_Len_Err(err0)
    );

    aw_write_arbiter_2m #(.S_Aw_len(8), .ARB_MODE(1)) dut_fp (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S00_AXI_awvalid(s00_valid), .S00_AXI_awlen(s00_len), .S00_AXI_awready(s00_rdy1),
        .S01_AXI_awvalid(s01_valid), .S01_AXI_awlen(s01_len), .S01_AXI_awready(s01_rdy1),
        .Selected_Slave(sel1), .M_AXI_awvalid(awv1), .M_AXI_awready(m_awready),
        .M_AXI_wvalid(m_wvalid), .M_AXI_wready(m_wready), .M_AXI_wlast(m_wlast),
        .M_AXI_bvalid(m_bvalid), .M_AXI_bready(m_bready),
        .Write_Data_Sel(wds1), .Arb_Busy(busy1), .W_Len_Err(err1)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        ARESETN   = 1'b0;
        s00_valid = 1'b0; s01_valid = 1'b0;
        s00_len   = 8'd0; s01_len   = 8'd0;
        m_awready = 1'b0; m_wvalid  = 1'b0; m_wready = 1'b0; m_wlast = 1'b0;
        m_bvalid  = 1'b0; m_bready  = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
    endtask

    // Drives one complete transaction starting from IDLE or AW; masters and
    // awlen are set up by the caller. Returns observations for the caller to judge.
    task automatic run_txn(input int nbeats, output logic g0, output logic g1,
                           output logic s01rdy_fp, output int err_cnt,
                           output int err_first, output logic busy_after_b,
                           output logic ok);
        int t;
        ok = 1'b1; err_cnt = 0; err_first = -1; s01rdy_fp = 1'b0;
        g0 = 1'bx; g1 = 1'bx; busy_after_b = 1'bx;
        t = 0;
        while (!busy0 && t < 20) begin
            @(negedge ACLK);
            t++;
        end
        if (!busy0) begin
            ok = 1'b0;
            return;
        end
        g0 = sel0;
        g1 = sel1;
        m_awready = 1'b1;
        #1;
        if (s01_rdy1) s01rdy_fp = 1'b1;
        @(negedge ACLK);
        m_awready = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            m_wvalid = 1'b1; m_wready = 1'b1; m_wlast = (i == nbeats - 1);
            #1;
            if (s01_rdy1) s01rdy_fp = 1'b1;
            @(negedge ACLK);
            if (err0) begin
                err_cnt++;
                if (err_first < 0) err_first = i;
            end
        end
        m_wvalid = 1'b0; m_wready = 1'b0; m_wlast = 1'b0;
        m_bvalid = 1'b1; m_bready = 1'b1;
        @(negedge ACLK);
        if (err0) err_cnt++;
        m_bvalid = 1'b0; m_bready = 1'b0;
        busy_after_b = busy0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++;
        if ({sel0, wds0, awv0, s00_rdy0, s01_rdy0, busy0, err0} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {sel0, wds0, awv0, s00_rdy0, s01_rdy0, busy0, err0});
        end
    endtask

    task automatic test_basic();
        logic g0, g1, s01fp, bab, ok;
        int ec, ef;
        apply_reset();
        s00_valid = 1'b1; s00_len = 8'd3;
        #1;
        n_checks++;
        if (awv0 !== 1'b0 || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: awvalid=%b busy=%b expected 0 0", awv0, busy0);
        end
        @(negedge ACLK);
        n_checks++;
        if (awv0 !== 1'b1 || busy0 !== 1'b1 || sel0 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency: awvalid=%b busy=%b sel=%b expected 1 1 0", awv0, busy0, sel0);
        end
        m_awready = 1'b1;
        #1;
        n_checks++;
        if (s00_rdy0 !== 1'b1 || s01_rdy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_awready: s00=%b s01=%b expected 1 0", s00_rdy0, s01_rdy0);
        end
        m_awready = 1'b0;
        run_txn(4, g0, g1, s01fp, ec, ef, bab, ok);
        s00_valid = 1'b0;
        n_checks++;
        if (ok !== 1'b1 || g0 !== 1'b0 || ec != 0 || bab !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_txn: ok=%b grant=%b errs=%0d busy_after_b=%b expected 1 0 0 0",
                     ok, g0, ec, bab);
        end
    endtask

    task automatic test_round_robin();
        logic g0, g1, s01fp, bab, ok;
        int ec, ef;
        logic [3:0] exp_order = 4'b1010;
        apply_reset();
        s00_valid = 1'b1; s01_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            run_txn(1, g0, g1, s01fp, ec, ef, bab, ok);
            n_checks++;
            if (ok !== 1'b1 || g0 !== exp_order[k] || bab !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: ok=%b grant=%b busy_after_b=%b expected 1 %b 0",
                         k, ok, g0, bab, exp_order[k]);
            end
        end
        s00_valid = 1'b0; s01_valid = 1'b0;
    endtask

    task automatic test_fixed_priority();
        logic g0, g1, s01fp, bab, ok;
        int ec, ef;
        apply_reset();
        s00_valid = 1'b1; s01_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            run_txn(1, g0, g1, s01fp, ec, ef, bab, ok);
            n_checks++;
            if (ok !== 1'b1 || g1 !== 1'b0 || s01fp !== 1'b0) begin
                n_fail++;
                $display("FAIL fp_grant[%0d]: ok=%b grant=%b s01_awready_seen=%b expected 1 0 0",
                         k, ok, g1, s01fp);
            end
        end
        s00_valid = 1'b0; s01_valid = 1'b0;
    endtask

    task automatic test_len_err();
        logic g0, g1, s01fp, bab, ok;
        int ec, ef;
        apply_reset();
        s00_valid = 1'b1; s00_len = 8'd2;
        run_txn(2, g0, g1, s01fp, ec, ef, bab, ok);
        n_checks++;
        if (ok !== 1'b1 || ec != 1 || ef != 1 || bab !== 1'b0) begin
            n_fail++;
            $display("FAIL len_err_early: ok=%b errs=%0d first_beat=%0d busy_after_b=%b expected 1 1 1 0",
                     ok, ec, ef, bab);
        end
        s00_len = 8'd0;
        run_txn(2, g0, g1, s01fp, ec, ef, bab, ok);
        s00_valid = 1'b0;
        n_checks++;
        if (ok !== 1'b1 || ec != 1 || ef != 0) begin
            n_fail++;
            $display("FAIL len_err_late: ok=%b errs=%0d first_beat=%0d expected 1 1 0", ok, ec, ef);
        end
    endtask

    task automatic test_back_to_back_wait();
        logic g0, g1, s01fp, bab, ok;
        int ec, ef;
        logic rdy_seen;
        apply_reset();
        s00_valid = 1'b1; s00_len = 8'd1;
        @(negedge ACLK);
        m_awready = 1'b1;
        @(negedge ACLK);
        s00_valid = 1'b0;
        s01_valid = 1'b1; s01_len = 8'd0;
        rdy_seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_wvalid = 1'b1; m_wready = 1'b1; m_wlast = (i == 1);
            #1;
            if (s01_rdy0 || awv0) rdy_seen = 1'b1;
            @(negedge ACLK);
        end
        m_wvalid = 1'b0; m_wready = 1'b0; m_wlast = 1'b0;
        #1;
        if (s01_rdy0 || awv0) rdy_seen = 1'b1;
        m_bvalid = 1'b1; m_bready = 1'b1;
        @(negedge ACLK);
        m_bvalid = 1'b0; m_bready = 1'b0;
        #1;
        if (s01_rdy0 || awv0) rdy_seen = 1'b1;
        n_checks++;
        if (rdy_seen !== 1'b0 || busy0 !== 1'b0 || sel0 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_during_txn: s01_ready_or_awvalid_seen=%b busy=%b sel=%b expected 0 0 0",
                     rdy_seen, busy0, sel0);
        end
        m_awready = 1'b0;
        run_txn(1, g0, g1, s01fp, ec, ef, bab, ok);
        s01_valid = 1'b0;
        n_checks++;
        if (ok !== 1'b1 || g0 !== 1'b1 || wds0 !== 1'b1) begin
            n_fail++;
            $display("FAIL next_grant_s01: ok=%b grant=%b wsel=%b expected 1 1 1", ok, g0, wds0);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic g0, g1, s01fp, bab, ok;
        int ec, ef;
        apply_reset();
        s00_valid = 1'b1;
        run_txn(1, g0, g1, s01fp, ec, ef, bab, ok);
        s00_valid = 1'b0;
        s01_valid = 1'b1; s01_len = 8'd3;
        @(negedge ACLK);
        m_awready = 1'b1;
        @(negedge ACLK);
        m_awready = 1'b0;
        m_wvalid = 1'b1; m_wready = 1'b1; m_wlast = 1'b0;
        @(negedge ACLK);
        n_checks++;
        if (sel0 !== 1'b1 || busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_state: sel=%b busy=%b expected 1 1", sel0, busy0);
        end
        m_awready = 1'b1;
        #2 ARESETN = 1'b0;
        #1;
        n_checks++;
        if ({sel0, wds0, awv0, s00_rdy0, s01_rdy0, busy0, err0} !== 7'b0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got %b expected 0000000",
                     {sel0, wds0, awv0, s00_rdy0, s01_rdy0, busy0, err0});
        end
        m_awready = 1'b0; m_wvalid = 1'b0; m_wready = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        s00_valid = 1'b1; s00_len = 8'd0; s01_len = 8'd0;
        run_txn(1, g0, g1, s01fp, ec, ef, bab, ok);
        s00_valid = 1'b0; s01_valid = 1'b0;
        n_checks++;
        if (ok !== 1'b1 || g0 !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_grant: ok=%b grant=%b expected 1 0", ok, g0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_fixed_priority();
        test_len_err();
        test_back_to_back_wait();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
